// File: rtl/decode_pipe.sv
// Decode stage: IF/ID register, bypassed register file, operand forwarding,
// branch/jump target generation and the ID/EX register.
module decode_pipe #(
    parameter int DATA_W         = 32,
    parameter int NREG           = 32,
    parameter bit FLUSH_ON_STALL = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       inst_f,
    input  logic [DATA_W-1:0] pc_plus4_f,
    input  logic              valid_f,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic [1:0]        sel_a_d,
    input  logic [1:0]        sel_b_d,
    input  logic [DATA_W-1:0] alu_result_e,
    input  logic [DATA_W-1:0] alu_result_m,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_en,
    output logic              equal_d,
    output logic [DATA_W-1:0] pc_branch_d,
    output logic [DATA_W-1:0] pc_jump_d,
    output logic              valid_e,
    output logic [DATA_W-1:0] read_data1_e,
    output logic [DATA_W-1:0] read_data2_e,
    output logic [DATA_W-1:0] imm_e,
    output logic [4:0]        rs_e,
    output logic [4:0]        rt_e,
    output logic [4:0]        rd_e
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [31:0]       inst_d;
    logic [DATA_W-1:0] pc_plus4_d;
    logic              valid_d;
    logic [DATA_W-1:0] rf [NREG];
    logic              do_stall;
    logic              do_flush;
    logic              wr_ok;
    logic [4:0]        rs_d;
    logic [4:0]        rt_d;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_d;
    logic              unused_opcode;

    // FLUSH_ON_STALL decides which one wins when both are raised together
    assign do_flush = flush_d && (!stall_d || FLUSH_ON_STALL);
    assign do_stall = stall_d && !do_flush;

    assign rs_d  = inst_d[25:21];
    assign rt_d  = inst_d[20:16];
    assign wr_ok = wb_en && (wb_addr != 5'd0)
                   && ({1'b0, wb_addr} < 6'(NREG));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_d     <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (do_flush) begin
            inst_d     <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!do_stall) begin
            inst_d     <= inst_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= valid_f;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_ok) begin
            rf[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    function automatic logic [DATA_W-1:0] rf_port(
        input logic [4:0]        a,
        input logic [DATA_W-1:0] stored,
        input logic              byp_en,
        input logic [4:0]        byp_addr,
        input logic [DATA_W-1:0] byp_data
    );
        if (a == 5'd0 || {1'b0, a} >= 6'(NREG)) begin
            return '0;
        end else if (byp_en && a == byp_addr) begin
            return byp_data;
        end
        return stored;
    endfunction

    function automatic logic [DATA_W-1:0] fwd(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rfv,
        input logic [DATA_W-1:0] res_e,
        input logic [DATA_W-1:0] res_m,
        input logic [DATA_W-1:0] res_w
    );
        logic [DATA_W-1:0] r;
        r = rfv;
        case (sel)
            2'd1:    r = res_e;
            2'd2:    r = res_m;
            2'd3:    r = res_w;
            default: r = rfv;
        endcase
        return r;
    endfunction

    always_comb begin
        rf_a = rf_port(rs_d, rf[rs_d[AW-1:0]], wr_ok, wb_addr, wb_data);
        rf_b = rf_port(rt_d, rf[rt_d[AW-1:0]], wr_ok, wb_addr, wb_data);
        op_a = fwd(sel_a_d, rf_a, alu_result_e, alu_result_m, wb_data);
        op_b = fwd(sel_b_d, rf_b, alu_result_e, alu_result_m, wb_data);
    end

    assign imm_d       = {{(DATA_W-16){inst_d[15]}}, inst_d[15:0]};
    assign equal_d     = valid_d && (op_a == op_b);
    assign pc_branch_d = pc_plus4_d + (imm_d << 2);
    assign pc_jump_d   = {pc_plus4_d[DATA_W-1:28], inst_d[25:0], 2'b00};

    assign unused_opcode = ^inst_d[31:26];

    // Invalid slots still carry their fields forward; only valid_e drops
    always_ff @(posedge clock or posedge reset) begin
        if (reset || do_stall) begin
            valid_e      <= 1'b0;
            read_data1_e <= '0;
            read_data2_e <= '0;
            imm_e        <= '0;
            rs_e         <= '0;
            rt_e         <= '0;
            rd_e         <= '0;
        end else begin
            valid_e      <= valid_d;
            read_data1_e <= op_a;
            read_data2_e <= op_b;
            imm_e        <= imm_d;
            rs_e         <= rs_d;
            rt_e         <= rt_d;
            rd_e         <= inst_d[15:11];
        end
    end

endmodule
